// File: rtl/y86_imem_loader.sv
// y86_imem_loader: writer side of the Y86-64 instruction memory.
// Accepts a framed byte stream (LEN_LO, LEN_HI, N payload bytes, CSUM = XOR of
// the payload) over valid/ready. Payload bytes are written to memory from
// address 0. The core is held in reset until a verified image is in place.
// Ports:
//   clk, rst        - rising-edge clock, synchronous active-high reset
//   start           - begins a new load (accepted only in IDLE/DONE/ERR)
//   in_valid/in_data/in_ready - stream byte handshake (in_ready is combinational)
//   mem_we/mem_addr/mem_wdata - registered instruction-memory byte write port
//   cpu_hold        - core held in reset while 1 (low only in DONE)
//   load_done/load_err - level status of the current or last load
//   bytes_loaded    - payload bytes written in the current or last load
module y86_imem_loader #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   bytes_loaded
);

    localparam int unsigned MAX_LEN = 2**ADDR_W;
    localparam int unsigned CNT_W   = ADDR_W + 1;

    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR
    } loaderState_t;

    loaderState_t state, stateNext;

    logic [15:0]       lenReg, lenNext, lenFull;
    logic [CNT_W-1:0]  idx, idxNext;
    logic [7:0]        xorAcc, xorNext;
    logic              weNext;
    logic [ADDR_W-1:0] addrNext;
    logic [7:0]        wdataNext;
    logic              holdNext, doneNext, errNext;
    logic [CNT_W-1:0]  cntNext;
    logic              xfer;

    // Stream is accepted only while a frame is being parsed.
    assign in_ready = (state == LEN_LO) || (state == LEN_HI) ||
                      (state == DATA)   || (state == CSUM);
    assign xfer     = in_valid && in_ready;

    // Next-state and next-register logic.
    always_comb begin
        stateNext = state;
        lenNext   = lenReg;
        lenFull   = {in_data, lenReg[7:0]};
        idxNext   = idx;
        xorNext   = xorAcc;
        weNext    = 1'b0;
        addrNext  = mem_addr;
        wdataNext = mem_wdata;
        doneNext  = load_done;
        errNext   = load_err;
        cntNext   = bytes_loaded;

        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    stateNext = LEN_LO;
                    doneNext  = 1'b0;
                    errNext   = 1'b0;
                    cntNext   = '0;
                    idxNext   = '0;
                    xorNext   = '0;
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    lenNext[7:0] = in_data;
                    stateNext    = LEN_HI;
                end
            end
            LEN_HI: begin
                if (xfer) begin
                    lenNext[15:8] = in_data;
                    if (32'(lenFull) > MAX_LEN) begin
                        stateNext = ERR;
                        errNext   = 1'b1;
                    end else if (lenFull == 16'd0) begin
                        stateNext = CSUM;
                    end else begin
                        stateNext = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    weNext    = 1'b1;
                    addrNext  = idx[ADDR_W-1:0];
                    wdataNext = in_data;
                    idxNext   = idx + CNT_W'(1);
                    xorNext   = xorAcc ^ in_data;
                    cntNext   = (bytes_loaded == CNT_W'(MAX_LEN)) ? bytes_loaded
                                                                  : bytes_loaded + CNT_W'(1);
                    // Leave DATA right after the Nth payload byte.
                    if ((32'(idx) + 32'd1) == 32'(lenReg)) begin
                        stateNext = CSUM;
                    end
                end
            end
            CSUM: begin
                if (xfer) begin
                    if (in_data == xorAcc) begin
                        stateNext = DONE;
                        doneNext  = 1'b1;
                    end else begin
                        stateNext = ERR;
                        errNext   = 1'b1;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase

        holdNext = (stateNext != DONE);
    end

    // State and output registers; reset also cancels any pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            lenReg       <= '0;
            idx          <= '0;
            xorAcc       <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cpu_hold     <= 1'b1;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            bytes_loaded <= '0;
        end else begin
            state        <= stateNext;
            lenReg       <= lenNext;
            idx          <= idxNext;
            xorAcc       <= xorNext;
            mem_we       <= weNext;
            mem_addr     <= addrNext;
            mem_wdata    <= wdataNext;
            cpu_hold     <= holdNext;
            load_done    <= doneNext;
            load_err     <= errNext;
            bytes_loaded <= cntNext;
        end
    end

endmodule
